// File: rtl/dmem_responder_if.sv
// CPU data-memory port plus verdict and store-log drain signals.
// The slave modport is the responder side; master is the CPU/host side.
interface dmem_responder_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        done;
  logic        pass;
  logic        err;
  logic [15:0] store_count;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_adr;
  logic [31:0] log_data;
  logic        log_ovf;

  modport slave (
    input  MemWrite, DataAdr, WriteData, log_ready,
    output ReadData, done, pass, err, store_count,
    output log_valid, log_adr, log_data, log_ovf
  );

  modport master (
    output MemWrite, DataAdr, WriteData, log_ready,
    input  ReadData, done, pass, err, store_count,
    input  log_valid, log_adr, log_data, log_ovf
  );
endinterface

// File: rtl/dmem_responder.sv
// Word RAM responder with signature verdict and store log: loads are combinational, stores land next edge.
// Log is a fall-through FIFO popped on log_valid & log_ready; a push into a full, unpopped log is dropped and flagged.
module dmem_responder #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] SIG_ADDR  = 32'h0000_0064,
  parameter logic [31:0] SIG_VALUE = 32'h0000_0007,
  parameter int          LOG_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LOG_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t        r_state;
  logic [31:0]   r_ram [DEPTH];
  logic [31:0]   r_sig;
  logic [31:0]   r_fifo_adr [LOG_DEPTH];
  logic [31:0]   r_fifo_dat [LOG_DEPTH];
  logic [LW-1:0] r_wptr;
  logic [LW-1:0] r_rptr;
  logic [LW:0]   r_cnt;
  logic          r_lv;
  logic          r_done;
  logic          r_pass;
  logic          r_err;
  logic          r_ovf;
  logic [15:0]   r_store_cnt;

  logic          w_aligned;
  logic          w_is_sig;
  logic          w_in_rng;
  logic [AW-1:0] w_ram_idx;
  logic          w_st;
  logic          w_ok;
  logic          w_log;
  logic          w_bad;
  logic          w_ram_we;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [LW:0]   w_cnt_nxt;

  assign w_aligned = (bus.DataAdr[1:0] == 2'b00);
  assign w_is_sig  = (bus.DataAdr == SIG_ADDR);
  assign w_in_rng  = (bus.DataAdr < 32'(DEPTH * 4));
  assign w_ram_idx = bus.DataAdr[AW+1:2];
  assign w_st      = bus.MemWrite && (r_state == RUN);
  assign w_ok      = w_aligned && (w_is_sig || w_in_rng);
  assign w_log     = w_st && w_ok;
  assign w_bad     = w_st && !w_ok;
  // Signature address wins over RAM even when it aliases a RAM word.
  assign w_ram_we  = w_log && !w_is_sig;

  assign w_full = (r_cnt == (LW+1)'(LOG_DEPTH));
  assign w_pop  = r_lv && bus.log_ready;
  assign w_push = w_log && (!w_full || w_pop);

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_idx] <= bus.WriteData;
    if (w_push) begin
      r_fifo_adr[r_wptr] <= bus.DataAdr;
      r_fifo_dat[r_wptr] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_sig       <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_store_cnt <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_lv        <= 1'b0;
    end else begin
      if (w_bad) r_err <= 1'b1;
      if (w_log && w_is_sig) begin
        r_sig   <= bus.WriteData;
        r_done  <= 1'b1;
        r_pass  <= (bus.WriteData == SIG_VALUE);
        r_state <= HALT;
      end
      if (w_log && (r_store_cnt != 16'hFFFF)) r_store_cnt <= r_store_cnt + 16'd1;
      if (w_log && !w_push) r_ovf <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= w_cnt_nxt;
      r_lv  <= (w_cnt_nxt != '0);
    end
  end

  assign bus.ReadData = (w_aligned && w_is_sig) ? r_sig :
                        (w_aligned && w_in_rng) ? r_ram[w_ram_idx] : 32'h0;

  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.err         = r_err;
  assign bus.store_count = r_store_cnt;
  assign bus.log_valid   = r_lv;
  assign bus.log_ovf     = r_ovf;
  assign bus.log_adr     = r_lv ? r_fifo_adr[r_rptr] : 32'h0;
  assign bus.log_data    = r_lv ? r_fifo_dat[r_rptr] : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder: one table row per clock, outputs checked 2ns after the edge.
module tb_dmem_responder;
  logic clk;
  logic reset;
  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH(64), .SIG_ADDR(32'h64), .SIG_VALUE(32'h7), .LOG_DEPTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] rd;
    logic [15:0] cnt;
    logic        done;
    logic        pass;
    logic        err;
    logic        lv;
    logic        ovf;
    logic [31:0] ladr;
    logic [31:0] ldat;
  } vec_t;

  vec_t tbl [64];
  int   n = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic add(input logic rst, input logic we, input logic [31:0] adr,
                     input logic [31:0] wd, input logic rdy, input logic [31:0] rd,
                     input logic [15:0] cnt, input logic done, input logic pass,
                     input logic err, input logic lv, input logic ovf,
                     input logic [31:0] ladr, input logic [31:0] ldat);
    tbl[n] = '{rst, we, adr, wd, rdy, rd, cnt, done, pass, err, lv, ovf, ladr, ldat};
    n++;
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.MemWrite = 1'b0;
    bus.DataAdr = 32'h0;
    bus.WriteData = 32'h0;
    bus.log_ready = 1'b0;

    // Two stores, load-back, signature pass, halted store, log drain
    add(1,0,32'h400,0,0,     0,0,0,0,0,0,0,0,0);
    add(0,1,32'h10,5,0,      5,1,0,0,0,1,0,32'h10,5);
    add(0,1,32'h14,9,0,      9,2,0,0,0,1,0,32'h10,5);
    add(0,0,32'h10,0,0,      5,2,0,0,0,1,0,32'h10,5);
    add(0,1,32'h64,7,0,      7,3,1,1,0,1,0,32'h10,5);
    add(0,1,32'h10,32'hAA,0, 5,3,1,1,0,1,0,32'h10,5);
    add(0,0,32'h64,0,1,      7,3,1,1,0,1,0,32'h14,9);
    add(0,0,32'h64,0,1,      7,3,1,1,0,1,0,32'h64,7);
    add(0,0,32'h64,0,1,      7,3,1,1,0,0,0,0,0);
    // Failing signature, then reset keeps RAM
    add(1,0,32'h10,0,0,      5,0,0,0,0,0,0,0,0);
    add(0,1,32'h64,6,0,      6,1,1,0,0,1,0,32'h64,6);
    add(1,0,32'h10,0,0,      5,0,0,0,0,0,0,0,0);
    // Misaligned and out-of-range stores
    add(0,1,32'h13,1,0,      0,0,0,0,1,0,0,0,0);
    add(0,1,32'h400,2,0,     0,0,0,0,1,0,0,0,0);
    add(0,0,32'h10,0,0,      5,0,0,0,1,0,0,0,0);
    // Overflow: nine stores into an eight-entry log, then drain
    add(1,0,32'h400,0,0,     0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 9; k++)
      add(0,1,32'(4*k),32'(4*k),0, 32'(4*k),16'(k+1),0,0,0,1,(k==8),0,0);
    for (int k = 1; k <= 8; k++)
      add(0,0,32'h20,0,1, 32'h20,9,0,0,0,(k<8),1,
          (k<8) ? 32'(4*k) : 32'h0, (k<8) ? 32'(4*k) : 32'h0);
    // Full log with simultaneous pop and push
    add(1,0,32'h400,0,0,     0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 8; k++)
      add(0,1,32'(4*k),32'(256+4*k),0, 32'(256+4*k),16'(k+1),0,0,0,1,0,0,32'h100);
    add(0,1,32'h20,32'h55,1, 32'h55,9,0,0,0,1,0,32'h4,32'h104);
    for (int k = 2; k <= 8; k++)
      add(0,0,32'h20,0,1, 32'h55,9,0,0,0,1,0,
          (k<8) ? 32'(4*k) : 32'h20, (k<8) ? 32'(256+4*k) : 32'h55);
    add(0,0,32'h20,0,1,      32'h55,9,0,0,0,0,0,0,0);

    for (int i = 0; i < n; i++) begin
      reset         = tbl[i].rst;
      bus.MemWrite  = tbl[i].we;
      bus.DataAdr   = tbl[i].adr;
      bus.WriteData = tbl[i].wd;
      bus.log_ready = tbl[i].rdy;
      @(posedge clk);
      #2;
      chk("ReadData",    i, bus.ReadData,           tbl[i].rd);
      chk("store_count", i, 32'(bus.store_count),   32'(tbl[i].cnt));
      chk("done",        i, 32'(bus.done),          32'(tbl[i].done));
      chk("pass",        i, 32'(bus.pass),          32'(tbl[i].pass));
      chk("err",         i, 32'(bus.err),           32'(tbl[i].err));
      chk("log_valid",   i, 32'(bus.log_valid),     32'(tbl[i].lv));
      chk("log_ovf",     i, 32'(bus.log_ovf),       32'(tbl[i].ovf));
      chk("log_adr",     i, bus.log_adr,            tbl[i].ladr);
      chk("log_data",    i, bus.log_data,           tbl[i].ldat);
    end

    // Store into an empty log: old RAM value before the edge, new value and log head after
    reset         = 1'b0;
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = 32'h10;
    bus.WriteData = 32'h33;
    bus.log_ready = 1'b0;
    #1;
    chk("rd_before_edge", n, bus.ReadData, 32'h110);
    chk("lv_before_edge", n, 32'(bus.log_valid), 32'h0);
    @(posedge clk);
    #2;
    bus.MemWrite = 1'b0;
    chk("rd_after_edge", n, bus.ReadData, 32'h33);
    chk("cnt_after_edge", n, 32'(bus.store_count), 32'd10);
    chk("lv_after_edge", n, 32'(bus.log_valid), 32'h1);
    chk("ladr_after_edge", n, bus.log_adr, 32'h10);
    chk("ldat_after_edge", n, bus.log_data, 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
